// File: rtl/sdram_access_arbiter.sv
// SDRAM access arbiter: shares the frame buffer between scan-out reads, MCU pixel
// writes and auto-refresh. Optional read starvation guard: SDRAM_ARB_STARVE_GUARD_EN.
module sdram_access_arbiter #(
   parameter int ADDR_W         = 22,
   parameter int LEN_W          = 8,
   parameter int REFRESH_CYCLES = 780,
   parameter int MAX_WR_BURSTS  = 4
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              init_done,
   input  logic              rd_req,
   input  logic              rd_urgent,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [LEN_W-1:0]  rd_len,
   output logic              rd_ack,
   output logic              rd_done,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LEN_W-1:0]  wr_len,
   output logic              wr_ack,
   output logic              wr_done,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [1:0]        cmd_op,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [LEN_W-1:0]  cmd_len,
   input  logic              cmd_done,
   output logic              refresh_overrun,
   output logic              busy,
   output logic [1:0]        fsm_state
);

   localparam logic [1:0] S_WAIT_INIT = 2'd0;
   localparam logic [1:0] S_IDLE      = 2'd1;
   localparam logic [1:0] S_ISSUE     = 2'd2;
   localparam logic [1:0] S_BUSY      = 2'd3;

   localparam logic [1:0] OP_WR  = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_REF = 2'b10;

   localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   logic [1:0]        state;
   logic [TMR_W-1:0]  timer;
   logic [1:0]        ref_pend;
   logic              timer_run;
   logic              tick;
   logic              accept;
   logic              accept_ref;
   logic              guard_hit;
   logic              grant;
   logic [1:0]        grant_op;
   logic [ADDR_W-1:0] grant_addr;
   logic [LEN_W-1:0]  grant_len;

   // Handshake: cmd_valid rises only in ISSUE, cmd_op/addr/len stay frozen while
   // cmd_valid=1, and the command transfers on the first edge with cmd_valid&cmd_ready.
   assign timer_run  = (state != S_WAIT_INIT) || init_done;
   assign tick       = timer_run && (timer == TMR_W'(REFRESH_CYCLES - 1));
   assign accept     = (state == S_ISSUE) && cmd_valid && cmd_ready;
   assign accept_ref = accept && (cmd_op == OP_REF);
   assign busy       = (state != S_IDLE);
   assign fsm_state  = state;

   always_ff @(posedge clk) begin
      if (RST || !timer_run) begin
         timer <= '0;
      end else if (tick) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   // A tick coinciding with an accepted refresh cancels out.
   always_ff @(posedge clk) begin
      if (RST) begin
         ref_pend        <= 2'd0;
         refresh_overrun <= 1'b0;
      end else begin
         case ({tick, accept_ref})
            2'b10: begin
               if (ref_pend == 2'd3) refresh_overrun <= 1'b1;
               else                  ref_pend <= ref_pend + 2'd1;
            end
            2'b01:   ref_pend <= ref_pend - 2'd1;
            default: ref_pend <= ref_pend;
         endcase
      end
   end

   always_comb begin
      grant      = 1'b0;
      grant_op   = OP_WR;
      grant_addr = '0;
      grant_len  = '0;
      if (state == S_IDLE) begin
         if (ref_pend != 2'd0) begin
            grant    = 1'b1;
            grant_op = OP_REF;
         end else if (rd_req && (rd_urgent || guard_hit)) begin
            grant      = 1'b1;
            grant_op   = OP_RD;
            grant_addr = rd_addr;
            grant_len  = rd_len;
         end else if (wr_req) begin
            grant      = 1'b1;
            grant_op   = OP_WR;
            grant_addr = wr_addr;
            grant_len  = wr_len;
         end else if (rd_req) begin
            grant      = 1'b1;
            grant_op   = OP_RD;
            grant_addr = rd_addr;
            grant_len  = rd_len;
         end
      end
   end

`ifdef SDRAM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(MAX_WR_BURSTS + 1);
   logic [CNT_W-1:0] wr_cnt;

   assign guard_hit = (wr_cnt == CNT_W'(MAX_WR_BURSTS));

   // Counts writes granted while a read waits; saturates at the limit.
   always_ff @(posedge clk) begin
      if (RST) begin
         wr_cnt <= '0;
      end else if (grant) begin
         if ((grant_op == OP_RD) || !rd_req) wr_cnt <= '0;
         else if ((grant_op == OP_WR) && !guard_hit) wr_cnt <= wr_cnt + 1'b1;
      end
   end
`else
   // Strict priority; MAX_WR_BURSTS only matters when the guard is built in.
   assign guard_hit = (MAX_WR_BURSTS < 0);
`endif

   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= S_WAIT_INIT;
         cmd_valid <= 1'b0;
         cmd_op    <= 2'b00;
         cmd_addr  <= '0;
         cmd_len   <= '0;
         rd_ack    <= 1'b0;
         rd_done   <= 1'b0;
         wr_ack    <= 1'b0;
         wr_done   <= 1'b0;
      end else begin
         rd_ack  <= 1'b0;
         rd_done <= 1'b0;
         wr_ack  <= 1'b0;
         wr_done <= 1'b0;
         case (state)
            S_WAIT_INIT: if (init_done) state <= S_IDLE;
            S_IDLE: begin
               if (grant) begin
                  cmd_valid <= 1'b1;
                  cmd_op    <= grant_op;
                  cmd_addr  <= grant_addr;
                  cmd_len   <= grant_len;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (accept) begin
                  cmd_valid <= 1'b0;
                  rd_ack    <= (cmd_op == OP_RD);
                  wr_ack    <= (cmd_op == OP_WR);
                  state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cmd_done) begin
                  rd_done <= (cmd_op == OP_RD);
                  wr_done <= (cmd_op == OP_WR);
                  state   <= S_IDLE;
               end
            end
            default: state <= S_WAIT_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench for sdram_access_arbiter: refresh timing, grants, overrun, guard, reset abort.
module tb_sdram_access_arbiter;

   localparam int ADDR_W         = 22;
   localparam int LEN_W          = 8;
   localparam int REFRESH_CYCLES = 780;
   localparam int MAX_WR_BURSTS  = 4;

   logic              clk = 1'b0;
   logic              RST = 1'b1;
   logic              init_done = 1'b0;
   logic              rd_req = 1'b0;
   logic              rd_urgent = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [LEN_W-1:0]  rd_len = '0;
   logic              wr_req = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [LEN_W-1:0]  wr_len = '0;
   logic              cmd_ready = 1'b0;
   logic              cmd_done = 1'b0;
   logic              rd_ack, rd_done, wr_ack, wr_done;
   logic              cmd_valid;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;
   logic              refresh_overrun;
   logic              busy;
   logic [1:0]        fsm_state;

   int checks = 0;
   int failures = 0;
   logic [1:0] exp_q[$];

   sdram_access_arbiter #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W),
      .REFRESH_CYCLES(REFRESH_CYCLES), .MAX_WR_BURSTS(MAX_WR_BURSTS)
   ) dut (
      .clk(clk), .RST(RST), .init_done(init_done),
      .rd_req(rd_req), .rd_urgent(rd_urgent), .rd_addr(rd_addr), .rd_len(rd_len),
      .rd_ack(rd_ack), .rd_done(rd_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
      .wr_ack(wr_ack), .wr_done(wr_done),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
      .refresh_overrun(refresh_overrun), .busy(busy), .fsm_state(fsm_state)
   );

   // Clock and reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; init_done = 1'b0; rd_req = 1'b0; rd_urgent = 1'b0; wr_req = 1'b0;
      cmd_ready = 1'b0; cmd_done = 1'b0;
      tick(); tick();
      RST = 1'b0;
   endtask

   task automatic do_init();
      init_done = 1'b1;
      tick();
   endtask

   // Driver: acts as the command engine for one command, optionally as the requester too.
   task automatic serve(input int done_delay, input bit keep_req, output logic [1:0] op,
                        output logic [ADDR_W-1:0] addr, output logic [LEN_W-1:0] len,
                        output bit timeout);
      timeout = 1'b0;
      op = 2'b11; addr = '0; len = '0;
      for (int i = 0; i < 2000 && cmd_valid !== 1'b1; i++) tick();
      if (cmd_valid !== 1'b1) begin
         timeout = 1'b1;
      end else begin
         op = cmd_op; addr = cmd_addr; len = cmd_len;
         cmd_ready = 1'b1;
         tick();
         cmd_ready = 1'b0;
         if (!keep_req) begin
            if (rd_ack === 1'b1) rd_req = 1'b0;
            if (wr_ack === 1'b1) wr_req = 1'b0;
         end
         repeat (done_delay) tick();
         cmd_done = 1'b1;
         tick();
         cmd_done = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      RST = 1'b1;
      tick();
      checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%0h exp=0", cmd_valid); end
      checks++; if ({cmd_op, cmd_addr, cmd_len} !== '0) begin failures++; $display("FAIL reset_cmd_fields got=%0h/%0h/%0h exp=0", cmd_op, cmd_addr, cmd_len); end
      checks++; if ({rd_ack, rd_done, wr_ack, wr_done} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%0b exp=0000", {rd_ack, rd_done, wr_ack, wr_done}); end
      checks++; if (refresh_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0h exp=0", refresh_overrun); end
      checks++; if (busy !== 1'b1 || fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=busy%0h/st%0d exp=busy1/st0", busy, fsm_state); end
      RST = 1'b0;
      repeat (20) tick();
      checks++; if (busy !== 1'b1 || cmd_valid !== 1'b0) begin failures++; $display("FAIL wait_init_hold got=busy%0h/valid%0h exp=busy1/valid0", busy, cmd_valid); end
   endtask

   task automatic test_first_refresh();
      int first;
      int pulses;
      do_reset();
      repeat (10) tick();
      init_done = 1'b1;
      first = 0; pulses = 0;
      for (int n = 1; n <= 800; n++) begin
         tick();
         if (n == 1) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_init got=%0h exp=0", busy); end
         end
         if ({rd_ack, rd_done, wr_ack, wr_done} !== 4'b0) pulses++;
         if (cmd_valid === 1'b1 && first == 0) first = n;
      end
      checks++; if (first !== 781) begin failures++; $display("FAIL first_refresh_cycle got=%0d exp=781", first); end
      checks++; if (cmd_op !== 2'b10 || cmd_addr !== '0 || cmd_len !== '0) begin failures++; $display("FAIL first_refresh_cmd got=%0h/%0h/%0h exp=2/0/0", cmd_op, cmd_addr, cmd_len); end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      if ({rd_ack, wr_ack} !== 2'b0) pulses++;
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      if ({rd_done, wr_done} !== 2'b0) pulses++;
      checks++; if (pulses !== 0) begin failures++; $display("FAIL refresh_no_pulses got=%0d exp=0", pulses); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL refresh_back_idle got=%0h exp=0", busy); end
   endtask

   task automatic test_write();
      int early;
      do_reset();
      do_init();
      cmd_ready = 1'b1;
      wr_addr = 22'h000100; wr_len = 8'hFF; wr_req = 1'b1;
      tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_op !== 2'b00) begin failures++; $display("FAIL wr_issue got=valid%0h/op%0h exp=valid1/op0", cmd_valid, cmd_op); end
      checks++; if (cmd_addr !== 22'h000100 || cmd_len !== 8'hFF) begin failures++; $display("FAIL wr_fields got=%0h/%0h exp=100/ff", cmd_addr, cmd_len); end
      checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_early got=%0h exp=0", wr_ack); end
      tick();
      checks++; if (wr_ack !== 1'b1 || cmd_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wr_ack_pulse got=ack%0h/valid%0h/busy%0h exp=1/0/1", wr_ack, cmd_valid, busy); end
      wr_req = 1'b0; cmd_ready = 1'b0;
      tick();
      checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_width got=%0h exp=0", wr_ack); end
      early = 0;
      repeat (258) begin
         tick();
         if (wr_done !== 1'b0 || busy !== 1'b1) early++;
      end
      checks++; if (early !== 0) begin failures++; $display("FAIL wr_busy_hold got=%0d exp=0", early); end
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      checks++; if (wr_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL wr_done_pulse got=done%0h/busy%0h exp=1/0", wr_done, busy); end
      tick();
      checks++; if (wr_done !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin failures++; $display("FAIL wr_after got=done%0h/busy%0h/valid%0h exp=0/0/0", wr_done, busy, cmd_valid); end
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      checks++; if ({rd_done, wr_done, busy} !== 3'b0) begin failures++; $display("FAIL stray_cmd_done got=%0b exp=000", {rd_done, wr_done, busy}); end
   endtask

   task automatic test_simultaneous();
      logic [1:0] op; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; bit to;
      do_reset();
      do_init();
      init_done = 1'b0;
      rd_addr = 22'h2A0000; rd_len = 8'h3F; wr_addr = 22'h000200; wr_len = 8'h07;
      rd_req = 1'b1; wr_req = 1'b1; rd_urgent = 1'b0;
      serve(3, 1'b0, op, a, l, to);
      checks++; if (to !== 1'b0 || op !== 2'b00 || a !== 22'h000200) begin failures++; $display("FAIL simul_first_wr got=to%0h/op%0h/a%0h exp=0/0/200", to, op, a); end
      tick();
      checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL turnaround got=%0h exp=1", cmd_valid); end
      serve(3, 1'b0, op, a, l, to);
      checks++; if (to !== 1'b0 || op !== 2'b01 || a !== 22'h2A0000 || l !== 8'h3F) begin failures++; $display("FAIL simul_then_rd got=to%0h/op%0h/a%0h/l%0h exp=0/1/2a0000/3f", to, op, a, l); end
      do_reset();
      do_init();
      rd_req = 1'b1; wr_req = 1'b1; rd_urgent = 1'b1;
      serve(2, 1'b0, op, a, l, to);
      checks++; if (to !== 1'b0 || op !== 2'b01) begin failures++; $display("FAIL urgent_first_rd got=to%0h/op%0h exp=0/1", to, op); end
      rd_urgent = 1'b0;
      serve(2, 1'b0, op, a, l, to);
      checks++; if (to !== 1'b0 || op !== 2'b00) begin failures++; $display("FAIL urgent_then_wr got=to%0h/op%0h exp=0/0", to, op); end
   endtask

   task automatic test_overrun();
      logic [1:0] op; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; bit to;
      logic [1:0] exp_op;
      do_reset();
      do_init();
      cmd_ready = 1'b0;
      for (int i = 0; i < 800 && cmd_valid !== 1'b1; i++) tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_op !== 2'b10) begin failures++; $display("FAIL ovr_first_ref got=valid%0h/op%0h exp=1/2", cmd_valid, cmd_op); end
      rd_addr = 22'h011000; wr_addr = 22'h022000; rd_req = 1'b1; wr_req = 1'b1;
      repeat (1570) tick();
      checks++; if (refresh_overrun !== 1'b0 || cmd_valid !== 1'b1 || cmd_op !== 2'b10) begin failures++; $display("FAIL ovr_pend3 got=ovr%0h/valid%0h/op%0h exp=0/1/2", refresh_overrun, cmd_valid, cmd_op); end
      repeat (780) tick();
      checks++; if (refresh_overrun !== 1'b1 || cmd_valid !== 1'b1) begin failures++; $display("FAIL ovr_set got=ovr%0h/valid%0h exp=1/1", refresh_overrun, cmd_valid); end
      exp_q = {2'b10, 2'b10, 2'b10, 2'b00};
      while (exp_q.size() > 0) begin
         exp_op = exp_q.pop_front();
         serve(1, 1'b0, op, a, l, to);
         checks++; if (to !== 1'b0 || op !== exp_op) begin failures++; $display("FAIL ovr_drain_seq got=to%0h/op%0h exp=0/%0h", to, op, exp_op); end
      end
      checks++; if (refresh_overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0h exp=1", refresh_overrun); end
      rd_req = 1'b0; wr_req = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checks++; if (refresh_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear_rst got=%0h exp=0", refresh_overrun); end
   endtask

   task automatic test_guard();
      logic [1:0] op; logic [ADDR_W-1:0] a; logic [LEN_W-1:0] l; bit to;
      logic [1:0] exp_op;
      do_reset();
      do_init();
      rd_req = 1'b1; wr_req = 1'b1; rd_urgent = 1'b0;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
      exp_q = {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
`else
      exp_q = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
      for (int g = 0; g < 6; g++) begin
         exp_op = exp_q.pop_front();
         serve(2, 1'b1, op, a, l, to);
         checks++; if (to !== 1'b0 || op !== exp_op) begin failures++; $display("FAIL guard_grant%0d got=to%0h/op%0h exp=0/%0h", g, to, op, exp_op); end
      end
      rd_req = 1'b0; wr_req = 1'b0;
   endtask

   task automatic test_reset_in_issue();
      int pulses;
      do_reset();
      do_init();
      cmd_ready = 1'b0;
      wr_addr = 22'h003300; wr_req = 1'b1;
      tick();
      checks++; if (cmd_valid !== 1'b1 || fsm_state !== 2'd2) begin failures++; $display("FAIL abort_in_issue got=valid%0h/st%0d exp=1/2", cmd_valid, fsm_state); end
      tick();
      RST = 1'b1;
      tick();
      checks++; if (cmd_valid !== 1'b0 || busy !== 1'b1 || fsm_state !== 2'd0) begin failures++; $display("FAIL abort_reset got=valid%0h/busy%0h/st%0d exp=0/1/0", cmd_valid, busy, fsm_state); end
      RST = 1'b0; wr_req = 1'b0; cmd_ready = 1'b1;
      pulses = 0;
      if ({rd_ack, rd_done, wr_ack, wr_done} !== 4'b0) pulses++;
      repeat (6) begin
         tick();
         if ({rd_ack, rd_done, wr_ack, wr_done} !== 4'b0) pulses++;
      end
      checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_no_pulses got=%0d exp=0", pulses); end
      cmd_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_refresh();
      test_write();
      test_simultaneous();
      test_overrun();
      test_guard();
      test_reset_in_issue();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
